// File: rtl/ads_pkg.sv
// Shared types and constants for the Avalon-MM busy poller.
// Holds the FSM state encoding and the saturating poll-counter helper.
package ads_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        LAT  = 3'd2,
        EVAL = 3'd3,
        GAP  = 3'd4,
        FIN  = 3'd5
    } ads_poll_state_t;

    localparam int ADS_BUSY_BIT   = 0;
    localparam int ADS_POLL_CNT_W = 16;

    // The poll counter must stick at all-ones instead of wrapping back to zero.
    function automatic logic [ADS_POLL_CNT_W-1:0] ads_sat_inc(
        input logic [ADS_POLL_CNT_W-1:0] cnt
    );
        if (cnt == {ADS_POLL_CNT_W{1'b1}}) begin
            return cnt;
        end else begin
            return cnt + ADS_POLL_CNT_W'(1);
        end
    endfunction

endpackage

// File: rtl/ads_busy_poller.sv
// Polls a busy status register over Avalon-MM until it clears, with an idle gap between polls.
// Define ADS_POLL_TIMEOUT_EN to stop after MAX_POLLS busy reads and flag timeout.
module ads_busy_poller
    import ads_pkg::*;
#(
    parameter int ADDR_W     = 2,
    parameter int BUSY_ADDR  = 0,
    parameter int GAP_CYCLES = 16,
    parameter int MAX_POLLS  = 1024
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      start,
    output logic                      done,
    output logic                      timeout,
    output logic [ADS_POLL_CNT_W-1:0] poll_count,
    output logic                      active,
    output logic [ADDR_W-1:0]         avm_address,
    output logic                      avm_read,
    input  logic                      avm_waitrequest,
    input  logic [31:0]               avm_readdata
);

`ifdef ADS_POLL_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    localparam logic [ADS_POLL_CNT_W-1:0] GAP_RELOAD = ADS_POLL_CNT_W'(GAP_CYCLES - 1);
    localparam logic [ADS_POLL_CNT_W-1:0] POLL_LIMIT = ADS_POLL_CNT_W'(MAX_POLLS);

    ads_poll_state_t             state_q, state_d;
    logic [ADS_POLL_CNT_W-1:0]   poll_cnt_q, poll_cnt_d;
    logic [ADS_POLL_CNT_W-1:0]   gap_cnt_q, gap_cnt_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        timeout_q, timeout_d;
    logic                        active_q, active_d;
    logic                        read_q, read_d;
    logic                        unused_rdata_s;

    assign unused_rdata_s = ^avm_readdata[31:1];

    // Next-state logic; outputs are derived from the next state so they line up with the registered state.
    always_comb begin
        state_d    = state_q;
        poll_cnt_d = poll_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        busy_d     = busy_q;
        timeout_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    poll_cnt_d = '0;
                    state_d    = REQ;
                end else begin
                    state_d = IDLE;
                end
            end
            REQ: begin
                if (!avm_waitrequest) begin
                    poll_cnt_d = ads_sat_inc(poll_cnt_q);
                    state_d    = LAT;
                end else begin
                    state_d = REQ;
                end
            end
            // Fixed read latency of one: data arrives the cycle after the accept.
            LAT: begin
                busy_d  = avm_readdata[ADS_BUSY_BIT];
                state_d = EVAL;
            end
            EVAL: begin
                if (!busy_q) begin
                    state_d = FIN;
                end else if (TIMEOUT_EN && (poll_cnt_q == POLL_LIMIT)) begin
                    state_d   = FIN;
                    timeout_d = 1'b1;
                end else begin
                    gap_cnt_d = GAP_RELOAD;
                    state_d   = GAP;
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) begin
                    state_d = REQ;
                end else begin
                    gap_cnt_d = gap_cnt_q - ADS_POLL_CNT_W'(1);
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        done_d   = (state_d == FIN);
        read_d   = (state_d == REQ);
        active_d = (state_d != IDLE);
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            poll_cnt_q <= '0;
            gap_cnt_q  <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            timeout_q  <= 1'b0;
            active_q   <= 1'b0;
            read_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            poll_cnt_q <= poll_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            timeout_q  <= timeout_d;
            active_q   <= active_d;
            read_q     <= read_d;
        end
    end

    assign done        = done_q;
    assign timeout     = timeout_q;
    assign poll_count  = poll_cnt_q;
    assign active      = active_q;
    assign avm_read    = read_q;
    assign avm_address = ADDR_W'(BUSY_ADDR);

endmodule

// File: tb/tb_ads_busy_poller.sv
// Scoreboard bench for ads_busy_poller: a latency-1 Avalon slave model returns a
// programmable number of busy reads; expected done results are queued at start.
module tb_ads_busy_poller;

    localparam int GAP   = 4;
    localparam int MAXP  = 5;
    localparam int BADDR = 2;
    localparam int STEP  = 3 + GAP;

    typedef struct {
        int t0;
        int polls;
        int to;
        int lat;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        done;
    logic        timeout;
    logic [15:0] poll_count;
    logic        active;
    logic [1:0]  avm_address;
    logic        avm_read;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_pass = 0;
    exp_t  sb[$];

    int          busy_cfg = 0;
    int          stall_cfg = 0;
    logic        new_seq = 1'b0;
    int          accept_cnt = 0;
    int          stall_left = 0;
    logic [30:0] junk = '0;

    ads_busy_poller #(
        .ADDR_W(2), .BUSY_ADDR(BADDR), .GAP_CYCLES(GAP), .MAX_POLLS(MAXP)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start), .done(done), .timeout(timeout),
        .poll_count(poll_count), .active(active), .avm_address(avm_address),
        .avm_read(avm_read), .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Slave model: stalls the first read, counts accepts, busy for the first busy_cfg reads.
    always @(posedge clk) begin
        junk <= 31'($urandom);
        if (new_seq) begin
            accept_cnt <= 0;
            stall_left <= stall_cfg;
        end else if (avm_read && stall_left > 0) begin
            stall_left <= stall_left - 1;
        end else if (avm_read) begin
            accept_cnt <= accept_cnt + 1;
        end
    end

    assign avm_waitrequest = avm_read && (stall_left > 0);
    assign avm_readdata    = {junk, (accept_cnt <= busy_cfg) ? 1'b1 : 1'b0};

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // Monitor: read handshake shape, address, and done results against the scoreboard.
    initial begin
        int   nrise = 0;
        int   hold = 0;
        int   last_rise = 0;
        logic prev_read = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (!reset_n) begin
                nrise = 0;
                hold = 0;
                prev_read = 1'b0;
            end else begin
                if (avm_read) begin
                    check_eq("read_addr", int'(avm_address), BADDR);
                    hold++;
                    if (!prev_read) begin
                        nrise++;
                        if (nrise >= 2)
                            check_eq("read_spacing", cyc - last_rise, STEP + ((nrise == 2) ? stall_cfg : 0));
                        last_rise = cyc;
                    end
                end else if (prev_read) begin
                    check_eq("read_hold", hold, 1 + ((nrise == 1) ? stall_cfg : 0));
                    hold = 0;
                end
                prev_read = avm_read;
                if (done) begin
                    if (sb.size() == 0) begin
                        check_eq("spurious_done", 1, 0);
                    end else begin
                        e = sb.pop_front();
                        check_eq("poll_count", int'(poll_count), e.polls);
                        check_eq("timeout", int'(timeout), e.to);
                        check_eq("latency", cyc - e.t0, e.lat);
                        check_eq("accepts", accept_cnt, e.polls);
                    end
                    nrise = 0;
                end
            end
        end
    end

    task automatic run_seq(input int busy, input int stall, input bit extra_start);
        exp_t e;
        @(negedge clk);
        busy_cfg  = busy;
        stall_cfg = stall;
`ifdef ADS_POLL_TIMEOUT_EN
        if (busy >= MAXP) begin
            e.polls = MAXP;
            e.to    = 1;
        end else begin
            e.polls = busy + 1;
            e.to    = 0;
        end
`else
        e.polls = busy + 1;
        e.to    = 0;
`endif
        e.lat = 4 + stall + STEP * (e.polls - 1);
        e.t0  = cyc;
        sb.push_back(e);
        start   = 1'b1;
        new_seq = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        new_seq = 1'b0;
        check_eq("active_after_start", int'(active), 1);
        if (extra_start) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (7) @(negedge clk);
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        for (int i = 0; i < 400 && sb.size() != 0; i++) @(negedge clk);
        if (sb.size() != 0) begin
            check_eq("done_seen", 0, 1);
            sb.delete();
        end
        repeat (3) @(negedge clk);
        check_eq("count_hold", int'(poll_count), e.polls);
        check_eq("idle_active", int'(active), 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check_eq("rst_done", int'(done), 0);
        check_eq("rst_timeout", int'(timeout), 0);
        check_eq("rst_active", int'(active), 0);
        check_eq("rst_read", int'(avm_read), 0);
        check_eq("rst_count", int'(poll_count), 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        run_seq(0, 0, 1'b0);
        run_seq(3, 0, 1'b0);
        run_seq(0, 3, 1'b0);
        run_seq(6, 0, 1'b0);

        // Abandon a sequence while it sits in the gap between polls.
        @(negedge clk);
        busy_cfg  = 10;
        stall_cfg = 0;
        start     = 1'b1;
        new_seq   = 1'b1;
        @(negedge clk);
        start   = 1'b0;
        new_seq = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("mid_active", int'(active), 1);
        check_eq("mid_count", int'(poll_count), 1);
        reset_n = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("mid_rst_active", int'(active), 0);
        check_eq("mid_rst_count", int'(poll_count), 0);
        check_eq("mid_rst_read", int'(avm_read), 0);
        reset_n = 1'b1;
        repeat (20) @(negedge clk);
        check_eq("post_rst_idle", int'(active), 0);

        run_seq(1, 0, 1'b0);
        run_seq(3, 0, 1'b1);
        run_seq(2, 2, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
